// File: rtl/matrix_scan_pkg.sv
// Shared definitions for the LED matrix row scanner: FSM state encoding and
// width helpers used to size the row index and the phase timer.
package matrix_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_e;

    // Bits needed to hold 0..n-1, never less than one so single-value counters stay legal.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/scan_counter.sv
// Modulo-N up counter with synchronous clear (clear wins over increment).
module scan_counter
    import matrix_scan_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned W = clog2_min1(N)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/matrix_scan_ctrl.sv
// Row-scanning LED matrix driver: blank/show phases per row, double-buffered
// frame data swapped only at frame boundaries, all outputs registered.
module matrix_scan_ctrl
    import matrix_scan_pkg::*;
#(
    parameter int unsigned ROWS  = 7,
    parameter int unsigned COLS  = 5,
    parameter int unsigned DWELL = 4,
    parameter int unsigned BLANK = 1,
    localparam int unsigned RW   = clog2_min1(ROWS)
) (
    input  logic                 clk_div,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 load,
    input  logic [ROWS*COLS-1:0] frame_data,
    output logic [ROWS-1:0]      rows,
    output logic [COLS-1:0]      cols,
    output logic [RW-1:0]        row_idx,
    output logic                 frame_done
);

    localparam int unsigned NB = ROWS * COLS;
    localparam int unsigned TN = max_u(BLANK, DWELL);
    localparam int unsigned TW = clog2_min1(TN);

    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK - 1);
    localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
    localparam scan_state_e   ST_FIRST   = (BLANK == 0) ? ST_SHOW : ST_BLANK;

    scan_state_e   state_q, state_d;
    logic [TW-1:0] tmr;
    logic          tmr_clr, tmr_inc;
    logic [RW-1:0] row_q, row_nxt;
    logic          row_clr, row_inc;
    logic          start, wrap;

    logic [NB-1:0] active_q, active_d;
    logic [NB-1:0] pend_q, pend_d;
    logic          pflag_q, pflag_d;

    logic [ROWS-1:0] rows_d;
    logic [COLS-1:0] cols_d;
    logic            frame_done_d;

    scan_counter #(.N(TN), .W(TW)) u_tmr (
        .clk_i  (clk_div),
        .rst_ni (rst_n),
        .clr_i  (tmr_clr),
        .inc_i  (tmr_inc),
        .cnt_o  (tmr)
    );

    scan_counter #(.N(ROWS), .W(RW)) u_row (
        .clk_i  (clk_div),
        .rst_ni (rst_n),
        .clr_i  (row_clr),
        .inc_i  (row_inc),
        .cnt_o  (row_q)
    );

    assign row_idx = row_q;

    // Next-state logic; drives the timer and row counter controls.
    always_comb begin
        state_d = state_q;
        tmr_clr = 1'b0;
        tmr_inc = 1'b0;
        row_clr = 1'b0;
        row_inc = 1'b0;
        start   = 1'b0;
        wrap    = 1'b0;
        if (!en) begin
            state_d = ST_IDLE;
            tmr_clr = 1'b1;
            row_clr = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_FIRST;
                    tmr_clr = 1'b1;
                    row_clr = 1'b1;
                    start   = 1'b1;
                end
                ST_BLANK: begin
                    if (tmr == BLANK_LAST) begin
                        state_d = ST_SHOW;
                        tmr_clr = 1'b1;
                    end else begin
                        tmr_inc = 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (tmr == DWELL_LAST) begin
                        state_d = ST_FIRST;
                        tmr_clr = 1'b1;
                        row_inc = 1'b1;
                        wrap    = (row_q == ROW_LAST);
                    end else begin
                        tmr_inc = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    tmr_clr = 1'b1;
                    row_clr = 1'b1;
                end
            endcase
        end
    end

    // Row the counter will hold after this edge, so the drivers can be registered alongside it.
    always_comb begin
        row_nxt = row_q;
        if (row_clr) begin
            row_nxt = '0;
        end else if (row_inc) begin
            row_nxt = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
        end
    end

    // Swap reads the pre-edge pending state; a coincident load then refills pending.
    always_comb begin
        active_d = active_q;
        pend_d   = pend_q;
        pflag_d  = pflag_q;
        if ((start || wrap) && pflag_q) begin
            active_d = pend_q;
            pflag_d  = 1'b0;
        end
        if (load) begin
            pend_d  = frame_data;
            pflag_d = 1'b1;
        end
    end

    // Output logic, evaluated on next-state values and captured in the state register.
    always_comb begin
        rows_d       = '1;
        cols_d       = '0;
        frame_done_d = wrap;
        if (state_d == ST_SHOW) begin
            rows_d[row_nxt] = 1'b0;
            cols_d          = active_d[row_nxt*COLS +: COLS];
        end
    end

    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rows       <= '1;
            cols       <= '0;
            frame_done <= 1'b0;
            active_q   <= '0;
            pend_q     <= '0;
            pflag_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rows       <= rows_d;
            cols       <= cols_d;
            frame_done <= frame_done_d;
            active_q   <= active_d;
            pend_q     <= pend_d;
            pflag_q    <= pflag_d;
        end
    end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Bench for matrix_scan_ctrl: default instance plus a BLANK=0/DWELL=1 instance,
// both checked every cycle against a frame-position reference model.
module tb_matrix_scan_ctrl;

    localparam int R  = 7;
    localparam int C  = 5;
    localparam int NB = R * C;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          load;
    logic [NB-1:0] fdata;

    logic [R-1:0] rows_a, rows_b;
    logic [C-1:0] cols_a, cols_b;
    logic [2:0]   ridx_a, ridx_b;
    logic         fd_a, fd_b;

    always #5 clk = ~clk;

    matrix_scan_ctrl dut_a (
        .clk_div    (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .frame_data (fdata),
        .rows       (rows_a),
        .cols       (cols_a),
        .row_idx    (ridx_a),
        .frame_done (fd_a)
    );

    matrix_scan_ctrl #(.DWELL(1), .BLANK(0)) dut_b (
        .clk_div    (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .frame_data (fdata),
        .rows       (rows_b),
        .cols       (cols_b),
        .row_idx    (ridx_b),
        .frame_done (fd_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: position within the frame, t in [0, frame period).
    bit            m_run[2];
    int            m_t[2];
    logic [NB-1:0] m_act[2];
    logic [NB-1:0] m_pend[2];
    bit            m_pf[2];
    bit            m_fd[2];

    function automatic int bl(input int k);
        return (k == 0) ? 1 : 0;
    endfunction

    function automatic int dw(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    task automatic mdl_reset();
        for (int k = 0; k < 2; k++) begin
            m_run[k]  = 1'b0;
            m_t[k]    = 0;
            m_act[k]  = '0;
            m_pend[k] = '0;
            m_pf[k]   = 1'b0;
            m_fd[k]   = 1'b0;
        end
    endtask

    task automatic mdl_step(input bit e, input bit ld, input logic [NB-1:0] d);
        for (int k = 0; k < 2; k++) begin
            int fp;
            fp = R * (bl(k) + dw(k));
            m_fd[k] = 1'b0;
            if (!e) begin
                m_run[k] = 1'b0;
                m_t[k]   = 0;
            end else if (!m_run[k]) begin
                m_run[k] = 1'b1;
                m_t[k]   = 0;
                if (m_pf[k]) begin
                    m_act[k] = m_pend[k];
                    m_pf[k]  = 1'b0;
                end
            end else begin
                m_t[k] = (m_t[k] + 1) % fp;
                if (m_t[k] == 0) begin
                    m_fd[k] = 1'b1;
                    if (m_pf[k]) begin
                        m_act[k] = m_pend[k];
                        m_pf[k]  = 1'b0;
                    end
                end
            end
            if (ld) begin
                m_pend[k] = d;
                m_pf[k]   = 1'b1;
            end
        end
    endtask

    task automatic mdl_check(input int k, input string pfx, input logic [R-1:0] r,
                             input logic [C-1:0] c, input logic [2:0] ri, input logic f);
        int            per, row, w;
        bit            lit;
        logic [R-1:0]  er;
        logic [C-1:0]  ec;
        logic [NB-1:0] sh;
        per = bl(k) + dw(k);
        row = m_t[k] / per;
        w   = m_t[k] % per;
        lit = m_run[k] && (w >= bl(k));
        er  = '1;
        ec  = '0;
        if (lit) begin
            er[row] = 1'b0;
            sh      = m_act[k] >> (row * C);
            ec      = sh[C-1:0];
        end
        chk({pfx, "_rows"}, 64'(r), 64'(er));
        chk({pfx, "_cols"}, 64'(c), 64'(ec));
        chk({pfx, "_row_idx"}, 64'(ri), m_run[k] ? 64'(row) : 64'd0);
        chk({pfx, "_frame_done"}, 64'(f), 64'(m_fd[k]));
    endtask

    task automatic step(input bit e, input bit ld, input logic [NB-1:0] d);
        en    = e;
        load  = ld;
        fdata = d;
        @(posedge clk);
        mdl_step(e, ld, d);
        #1;
        mdl_check(0, "a", rows_a, cols_a, ridx_a, fd_a);
        mdl_check(1, "b", rows_b, cols_b, ridx_b, fd_b);
        if (m_run[1]) begin
            chk("b_never_dark", 64'(rows_b != '1), 64'd1);
        end
    endtask

    task automatic run_until(input int target, input int budget);
        int n;
        n = 0;
        while (!(m_run[0] && m_t[0] == target) && n < budget) begin
            step(1'b1, 1'b0, '0);
            n++;
        end
        if (n >= budget) begin
            chk("run_until_timeout", 64'(m_t[0]), 64'(target));
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_a_rows"}, 64'(rows_a), 64'h7F);
        chk({tag, "_a_cols"}, 64'(cols_a), 64'd0);
        chk({tag, "_a_row_idx"}, 64'(ridx_a), 64'd0);
        chk({tag, "_a_frame_done"}, 64'(fd_a), 64'd0);
        chk({tag, "_b_rows"}, 64'(rows_b), 64'h7F);
        chk({tag, "_b_cols"}, 64'(cols_b), 64'd0);
    endtask

    logic [NB-1:0] dat_a, dat_b, rnd;
    bit            re, rl;

    initial begin
        rst_n = 1'b1;
        en    = 1'b0;
        load  = 1'b0;
        fdata = '0;
        mdl_reset();
        #1 rst_n = 1'b0;
        #3;
        check_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Reference pattern: one blank, row 0 for four cycles, blank, row 1.
        step(1'b0, 1'b1, 35'h1_2345_6789);
        step(1'b1, 1'b0, '0);
        chk("pat_blank0", 64'(rows_a), 64'h7F);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, '0);
            chk("pat_row0_rows", 64'(rows_a), 64'b1111110);
            chk("pat_row0_cols", 64'(cols_a), 64'b01001);
        end
        step(1'b1, 1'b0, '0);
        chk("pat_blank1", 64'(rows_a), 64'h7F);
        step(1'b1, 1'b0, '0);
        chk("pat_row1_rows", 64'(rows_a), 64'b1111101);
        chk("pat_row1_cols", 64'(cols_a), 64'b11100);
        for (int i = 7; i <= 35; i++) begin
            step(1'b1, 1'b0, '0);
        end
        chk("frame_done_at_35", 64'(fd_a), 64'd1);
        for (int i = 0; i < 34; i++) begin
            step(1'b1, 1'b0, '0);
        end
        step(1'b1, 1'b0, '0);
        chk("frame_done_at_70", 64'(fd_a), 64'd1);

        // New frame loaded mid-frame shows only from the next row 0.
        dat_a = {$urandom(), $urandom()};
        dat_a[4:0] = 5'h0A;
        run_until(16, 40);
        step(1'b1, 1'b1, dat_a);
        run_until(0, 40);
        step(1'b1, 1'b0, '0);
        chk("midframe_load_row0", 64'(cols_a), 64'h0A);

        // Second load on the wrap edge while the first is still pending.
        dat_a = {$urandom(), $urandom()};
        dat_a[4:0] = 5'h15;
        dat_b = {$urandom(), $urandom()};
        dat_b[4:0] = 5'h0E;
        run_until(20, 40);
        step(1'b1, 1'b1, dat_a);
        run_until(34, 40);
        step(1'b1, 1'b1, dat_b);
        chk("wrap_load_fd", 64'(fd_a), 64'd1);
        step(1'b1, 1'b0, '0);
        chk("wrap_load_first", 64'(cols_a), 64'h15);
        run_until(0, 40);
        step(1'b1, 1'b0, '0);
        chk("wrap_load_second", 64'(cols_a), 64'h0E);

        // Disable during row 4 show, then restart.
        run_until(22, 40);
        step(1'b0, 1'b0, '0);
        check_idle("en_drop");
        step(1'b1, 1'b0, '0);
        chk("restart_blank", 64'(rows_a), 64'h7F);
        step(1'b1, 1'b0, '0);
        chk("restart_row0", 64'(rows_a), 64'b1111110);

        for (int i = 0; i < 1500; i++) begin
            re  = ($urandom_range(0, 99) < 97);
            rl  = ($urandom_range(0, 99) < 6);
            rnd = {$urandom(), $urandom()};
            step(re, rl, rnd);
        end

        // Asynchronous reset mid-show clears the buffers too.
        step(1'b1, 1'b1, {$urandom(), $urandom()});
        run_until(12, 40);
        #2 rst_n = 1'b0;
        #1;
        check_idle("async_rst");
        mdl_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b0, '0);
            chk("post_rst_cols", 64'(cols_a), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/matrix_scan_ctrl.md
MATRIX_SCAN_CTRL -- requirements
Module: matrix_scan_ctrl

Interface
REQ-001 Parameter ROWS, default 7, number of matrix rows scanned (2..16).
REQ-002 Parameter COLS, default 5, number of column lines per row (1..16).
REQ-003 Parameter DWELL, default 4, clock cycles each row is lit (>=1).
REQ-004 Parameter BLANK, default 1, all-off cycles before each row (>=0), for ghost suppression.
REQ-005 clk_div  input  1  scan clock; one clock only, all state on its rising edge.
REQ-006 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-007 en  input  1  scan enable; high = scanning, low = return to idle.
REQ-008 load  input  1  single-cycle strobe; captures frame_data into the pending buffer.
REQ-009 frame_data  input  ROWS*COLS  new frame; row r occupies bits [r*COLS +: COLS], 1 = LED on.
REQ-010 rows  output  ROWS  row drivers, active-low, one-cold while lit.
REQ-011 cols  output  COLS  column drivers, active-high, active-buffer slice of the lit row.
REQ-012 row_idx  output  clog2(ROWS)  index of the current row.
REQ-013 frame_done  output  1  one-cycle pulse on completion of row ROWS-1.

Function
REQ-014 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-015 FSM states: IDLE, BLANK, SHOW.
REQ-016 IDLE: rows all 1, cols all 0, row_idx 0; en=1 sampled -> BLANK (SHOW if BLANK=0) on that edge, row_idx 0.
REQ-017 BLANK: rows all 1, cols all 0 for exactly BLANK cycles, then SHOW.
REQ-018 SHOW: rows[row_idx]=0, others 1, cols = active[row_idx*COLS +: COLS] for exactly DWELL cycles.
REQ-019 End of SHOW: row_idx increments and wraps from ROWS-1 to 0; next state BLANK (or SHOW if BLANK=0).
REQ-020 Frame period SHALL be ROWS*(BLANK+DWELL) cycles.
REQ-021 Wrap from ROWS-1 SHALL assert frame_done for exactly one cycle, coincident with the first cycle of the new frame.
REQ-022 load=1 SHALL copy frame_data into pending and set the pending flag; a load while pending is set overwrites it.
REQ-023 At the wrap, if pending is set, active takes pending and the flag clears; the display never changes mid-frame.
REQ-024 load on the wrap edge: the swap uses pre-edge pending, then the new data is written to pending with the flag left set.
REQ-025 en=0 in any state -> IDLE on the next edge, row_idx 0; a frame in progress is abandoned without frame_done.
REQ-026 Re-enable always starts at row 0 with a full BLANK period.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, rows all 1, cols all 0, row_idx 0, and frame_done 0.
REQ-028 rst_n=0 SHALL also clear the active buffer, the pending buffer and the pending flag.
REQ-029 Reset release: the first evaluated edge behaves as IDLE.

Structure
REQ-030 Shared package matrix_scan_pkg SHALL hold the state encoding (IDLE=0, BLANK=1, SHOW=2) and a clog2 helper for the row_idx and timer widths.
REQ-031 One sub-module scan_counter: parametrised modulo-N counter with rst_n and clear/inc, instanced for the dwell/blank timer and for the row index.
REQ-032 The frame buffers and FSM live in matrix_scan_ctrl.

Verification (ROWS=7, COLS=5, DWELL=4, BLANK=1 unless noted)
REQ-033 Load 0x1_2345_6789, en=1 -> one blank cycle; rows=7'b1111110 for 4 cycles with cols=5'b01001; then 1 blank; then rows=7'b1111101 with cols=5'b11100; frame_done every 35 cycles.
REQ-034 Load new data during row 3 -> rows 3..6 keep old data; new data first appears at row 0 after frame_done; pending clears.
REQ-035 load asserted on the frame_done cycle with data B while A is pending -> A is displayed in the new frame, and B is displayed in the following frame.
REQ-036 en dropped during row 4 SHOW -> next edge rows=7'h7F, cols=0, row_idx=0, no frame_done; en raised again -> restarts at row 0 after 1 blank.
REQ-037 rst_n pulsed low mid-SHOW, asynchronously -> outputs go inactive before the next edge; after release and en=1, cols=0 on every row (buffers cleared).
REQ-038 BLANK=0, DWELL=1 -> rows advances every cycle, 7-cycle frame, rows never all-1 while en=1.
